// File: rtl/online_arith_defs.sv
// rtl/online_arith_defs.sv - shared signed-digit encoding constants, width helpers and default taps
`define ONLINE_OD(s, c, t) ((s) + (c) + online_arith_defs::clog2(t))

package online_arith_defs;

   localparam int PLUS_BIT  = 1;
   localparam int MINUS_BIT = 0;

   localparam logic [63:0] DEFAULT_COEF_INIT =
      {8'd2, 8'd14, 8'd44, 8'd74, 8'd74, 8'd44, 8'd14, 8'd2};

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/online_adder.sv
// rtl/online_adder.sv - exact N-digit signed-digit adder, result renormalised to sign-magnitude digits
module online_adder
   import online_arith_defs::*;
#(
   parameter int N = 19
) (
   input  logic [2*N-1:0] i_a,
   input  logic [2*N-1:0] i_b,
   output logic [2*N-1:0] o_s
);
   logic [N-1:0] w_ap, w_am, w_bp, w_bm, w_neg;
   logic [N:0]   w_d;

   always_comb begin
      w_ap = '0;
      w_am = '0;
      w_bp = '0;
      w_bm = '0;
      for (int i = 0; i < N; i++) begin
         w_ap[i] = i_a[2*i+PLUS_BIT];
         w_am[i] = i_a[2*i+MINUS_BIT];
         w_bp[i] = i_b[2*i+PLUS_BIT];
         w_bm[i] = i_b[2*i+MINUS_BIT];
      end
   end

   // the true sum lies strictly inside +/-2^N, so N+1 bit wraparound arithmetic is exact
   assign w_d   = {1'b0, w_ap} + {1'b0, w_bp} - {1'b0, w_am} - {1'b0, w_bm};
   assign w_neg = -w_d[N-1:0];

   always_comb begin
      o_s = '0;
      for (int i = 0; i < N; i++) begin
         o_s[2*i+PLUS_BIT]  = ~w_d[N] & w_d[i];
         o_s[2*i+MINUS_BIT] = w_d[N] & w_neg[i];
      end
   end

endmodule

// File: rtl/online_ccm_prog.sv
// rtl/online_ccm_prog.sv - signed-digit sample times unsigned coefficient, shifted partial-product sum
module online_ccm_prog
   import online_arith_defs::*;
#(
   parameter int STAGE = 8,
   parameter int CW    = 8
) (
   input  logic [2*STAGE-1:0]      i_x,
   input  logic [CW-1:0]           i_c,
   output logic [2*(STAGE+CW)-1:0] o_y
);
   localparam int PW = STAGE + CW;

   logic [PW-1:0] w_xp, w_xm, w_sp, w_sm;

   // plus and minus rails are multiplied independently; neither sum can exceed PW bits
   always_comb begin
      w_xp = '0;
      w_xm = '0;
      for (int i = 0; i < STAGE; i++) begin
         w_xp[i] = i_x[2*i+PLUS_BIT];
         w_xm[i] = i_x[2*i+MINUS_BIT];
      end
      w_sp = '0;
      w_sm = '0;
      for (int j = 0; j < CW; j++) begin
         if (i_c[j]) begin
            w_sp = w_sp + (w_xp << j);
            w_sm = w_sm + (w_xm << j);
         end
      end
   end

   always_comb begin
      o_y = '0;
      for (int i = 0; i < PW; i++) begin
         o_y[2*i+PLUS_BIT]  = w_sp[i];
         o_y[2*i+MINUS_BIT] = w_sm[i];
      end
   end

endmodule

// File: rtl/online_fir_zero_prog.sv
// rtl/online_fir_zero_prog.sv - programmable double-banked signed-digit FIR zero section, 2-cycle pipeline
module online_fir_zero_prog
   import online_arith_defs::*;
#(
   parameter int STAGE = 8,
   parameter int TAPS  = 8,
   parameter int CW    = 8,
   parameter logic [TAPS*CW-1:0] COEF_INIT = DEFAULT_COEF_INIT
) (
   input  logic                                   clk,
   input  logic                                   nrst,
   input  logic                                   in_valid,
   input  logic                                   flush,
   input  logic [2*STAGE-1:0]                     din,
   input  logic                                   coef_we,
   input  logic [clog2(TAPS)-1:0]                 coef_addr,
   input  logic [CW-1:0]                          coef_data,
   input  logic                                   coef_commit,
   output logic                                   coef_pending,
   output logic                                   out_valid,
   output logic [2*`ONLINE_OD(STAGE, CW, TAPS)-1:0] data_out
);
   localparam int AW = clog2(TAPS);
   localparam int OD = `ONLINE_OD(STAGE, CW, TAPS);
   localparam int PW = STAGE + CW;
   localparam int NP = 1 << AW;

   logic [2*STAGE-1:0] r_dline  [TAPS];
   logic [CW-1:0]      r_shadow [TAPS];
   logic [CW-1:0]      r_active [TAPS];
   logic [2*PW-1:0]    r_prod   [TAPS];
   logic [2*PW-1:0]    w_prod   [TAPS];
   logic [2*OD-1:0]    r_out;
   logic [2*OD-1:0]    w_sum;
   logic               r_cap, r_pvld, r_ovld, r_pending;
   logic               w_addr_ok;

   if (TAPS == NP) begin : g_addr_full
      assign w_addr_ok = 1'b1;
   end else begin : g_addr_chk
      assign w_addr_ok = (coef_addr < AW'(TAPS));
   end

   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      online_ccm_prog #(.STAGE(STAGE), .CW(CW)) u_ccm (
         .i_x (r_dline[k]),
         .i_c (r_active[k]),
         .o_y (w_prod[k])
      );
   end

   // balanced tree over a power-of-two leaf count, unused leaves tied to zero
   for (genvar l = 0; l <= AW; l++) begin : g_lvl
      logic [2*OD-1:0] w_s [NP >> l];
      for (genvar i = 0; i < (NP >> l); i++) begin : g_n
         if (l == 0) begin : g_leaf
            if (i < TAPS) begin : g_used
               assign w_s[i] = {{(2*(OD-PW)){1'b0}}, r_prod[i]};
            end else begin : g_pad
               assign w_s[i] = '0;
            end
         end else begin : g_add
            online_adder #(.N(OD)) u_add (
               .i_a (g_lvl[l-1].w_s[2*i]),
               .i_b (g_lvl[l-1].w_s[2*i+1]),
               .o_s (w_s[i])
            );
         end
      end
   end

   assign w_sum = g_lvl[AW].w_s[0];

   // commit reads the pre-write shadow because both use the values from before this edge
   always_ff @(posedge clk) begin
      if (!nrst) begin
         for (int k = 0; k < TAPS; k++) begin
            r_dline[k]  <= '0;
            r_prod[k]   <= '0;
            r_shadow[k] <= COEF_INIT[k*CW +: CW];
            r_active[k] <= COEF_INIT[k*CW +: CW];
         end
         r_cap     <= 1'b0;
         r_pvld    <= 1'b0;
         r_ovld    <= 1'b0;
         r_out     <= '0;
         r_pending <= 1'b0;
      end else begin
         if (coef_commit) begin
            for (int k = 0; k < TAPS; k++) r_active[k] <= r_shadow[k];
         end
         if (coef_we && w_addr_ok) r_shadow[coef_addr] <= coef_data;
         if (coef_we)          r_pending <= 1'b1;
         else if (coef_commit) r_pending <= 1'b0;

         for (int k = 0; k < TAPS; k++) r_prod[k] <= w_prod[k];

         if (flush) begin
            for (int k = 0; k < TAPS; k++) r_dline[k] <= '0;
            r_cap  <= 1'b0;
            r_pvld <= 1'b0;
            r_ovld <= 1'b0;
         end else begin
            if (in_valid) begin
               r_dline[0] <= din;
               for (int k = 1; k < TAPS; k++) r_dline[k] <= r_dline[k-1];
            end
            r_cap  <= in_valid;
            r_pvld <= r_cap;
            r_ovld <= r_pvld;
            if (r_pvld) r_out <= w_sum;
         end
      end
   end

   assign coef_pending = r_pending;
   assign out_valid    = r_ovld;
   assign data_out     = r_out;

endmodule

// File: tb/tb_online_fir_zero_prog.sv
// tb/tb_online_fir_zero_prog.sv - self-checking bench for online_fir_zero_prog against a value-level model
module tb_online_fir_zero_prog;
   localparam int STAGE = 8;
   localparam int TAPS  = 8;
   localparam int CW    = 8;
   localparam int OD    = STAGE + CW + $clog2(TAPS);

   logic              clk = 1'b0;
   logic              nrst;
   logic              in_valid;
   logic              flush;
   logic [2*STAGE-1:0] din;
   logic              coef_we;
   logic [2:0]        coef_addr;
   logic [CW-1:0]     coef_data;
   logic              coef_commit;
   logic              coef_pending;
   logic              out_valid;
   logic [2*OD-1:0]   data_out;

   online_fir_zero_prog dut (
      .clk          (clk),
      .nrst         (nrst),
      .in_valid     (in_valid),
      .flush        (flush),
      .din          (din),
      .coef_we      (coef_we),
      .coef_addr    (coef_addr),
      .coef_data    (coef_data),
      .coef_commit  (coef_commit),
      .coef_pending (coef_pending),
      .out_valid    (out_valid),
      .data_out     (data_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     due;
      longint val;
   } ent_t;

   int     checks = 0;
   int     errors = 0;
   int     cyc    = 0;
   int     init_c [TAPS] = '{2, 14, 44, 74, 74, 44, 14, 2};
   int     sh     [TAPS];
   int     act    [TAPS];
   longint win    [TAPS];
   ent_t   pend_q [$];
   logic   m_pending;
   longint m_out;
   logic   exp_v;

   function automatic longint sd_val(input logic [63:0] v, input int nd);
      longint r;
      r = 0;
      for (int i = 0; i < nd; i++) begin
         if (v[2*i+1]) r += (longint'(1) << i);
         if (v[2*i])   r -= (longint'(1) << i);
      end
      return r;
   endfunction

   // random redundant encoding: pick plus rail, minus rail follows from the value
   function automatic logic [15:0] enc(input int v);
      int lo, hi, p, m;
      logic [15:0] r;
      lo = (v > 0) ? v : 0;
      hi = (v < 0) ? 255 + v : 255;
      p  = lo + int'($urandom_range(hi - lo));
      m  = p - v;
      for (int i = 0; i < 8; i++) begin
         r[2*i+1] = p[i];
         r[2*i]   = m[i];
      end
      return r;
   endfunction

   task automatic step();
      longint acc;
      @(posedge clk);
      cyc++;
      if (!nrst) begin
         for (int k = 0; k < TAPS; k++) begin
            sh[k] = init_c[k]; act[k] = init_c[k]; win[k] = 0;
         end
         pend_q.delete();
         m_pending = 1'b0;
         m_out     = 0;
      end else begin
         if (coef_commit) for (int k = 0; k < TAPS; k++) act[k] = sh[k];
         if (coef_we) sh[coef_addr] = int'(coef_data);
         if (coef_we) m_pending = 1'b1;
         else if (coef_commit) m_pending = 1'b0;
         if (flush) begin
            for (int k = 0; k < TAPS; k++) win[k] = 0;
            pend_q.delete();
         end else if (in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) win[k] = win[k-1];
            win[0] = sd_val(64'(din), STAGE);
            acc = 0;
            for (int k = 0; k < TAPS; k++) acc += longint'(act[k]) * win[k];
            pend_q.push_back('{cyc + 2, acc});
         end
      end
      exp_v = (pend_q.size() > 0) && (pend_q[0].due == cyc);
      if (exp_v) begin
         m_out = pend_q[0].val;
         void'(pend_q.pop_front());
      end
      #1;
      checks++;
      assert (out_valid === exp_v) else begin
         errors++;
         $error("FAIL out_valid cyc=%0d observed=%0b expected=%0b", cyc, out_valid, exp_v);
      end
      checks++;
      assert (sd_val(64'(data_out), OD) === m_out) else begin
         errors++;
         $error("FAIL data_out cyc=%0d observed=%0d expected=%0d", cyc, sd_val(64'(data_out), OD), m_out);
      end
      checks++;
      assert (coef_pending === m_pending) else begin
         errors++;
         $error("FAIL coef_pending cyc=%0d observed=%0b expected=%0b", cyc, coef_pending, m_pending);
      end
   endtask

   task automatic feed(input logic v, input logic [15:0] d);
      in_valid = v;
      din      = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) feed(1'b0, 16'h0000);
   endtask

   task automatic check_const(input string tag, input longint expv);
      checks++;
      assert (sd_val(64'(data_out), OD) === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, sd_val(64'(data_out), OD), expv);
      end
   endtask

   initial begin
      nrst = 1'b0; in_valid = 1'b0; flush = 1'b0; din = '0;
      coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
      step();
      step();
      nrst = 1'b1;

      // impulse with default taps, then redundant +1 and -1
      feed(1'b1, 16'h0002); feed(1'b1, 16'h0000); feed(1'b1, 16'h0000);
      check_const("impulse_first", 2);
      repeat (5) feed(1'b1, 16'h0000);
      idle(3);
      feed(1'b1, 16'h0009); repeat (7) feed(1'b1, 16'h0000); idle(3);
      feed(1'b1, 16'h0001); feed(1'b1, 16'h0000); feed(1'b1, 16'h0000);
      check_const("impulse_neg", -2);
      repeat (5) feed(1'b1, 16'h0000);
      idle(3);

      // full scale both signs
      repeat (10) feed(1'b1, 16'hAAAA);
      check_const("full_pos", 68340);
      repeat (10) feed(1'b1, 16'h5555);
      check_const("full_neg", -68340);
      repeat (8) feed(1'b1, 16'h0000);
      idle(3);

      // program taps 1,0,0,... and commit on the capture edge of a +1 impulse
      for (int k = 0; k < TAPS; k++) begin
         coef_we = 1'b1; coef_addr = 3'(k); coef_data = (k == 0) ? 8'd1 : 8'd0;
         step();
      end
      coef_we = 1'b0;
      coef_commit = 1'b1;
      feed(1'b1, enc(1));
      coef_commit = 1'b0;
      feed(1'b1, 16'h0000); feed(1'b1, 16'h0000);
      check_const("commit_edge", 1);
      repeat (6) feed(1'b1, 16'h0000);

      // write and commit together: commit takes the old shadow, pending stays set
      coef_we = 1'b1; coef_addr = 3'd1; coef_data = 8'd5; coef_commit = 1'b1;
      step();
      coef_we = 1'b0; coef_commit = 1'b0;
      feed(1'b1, enc(3)); repeat (8) feed(1'b1, 16'h0000);
      coef_commit = 1'b1; step(); coef_commit = 1'b0;

      // gaps between samples, then flush mid-response
      feed(1'b1, enc(7)); idle(3); repeat (8) feed(1'b1, 16'h0000);
      feed(1'b1, enc(-9)); feed(1'b1, 16'h0000); feed(1'b1, 16'h0000);
      flush = 1'b1; feed(1'b1, enc(100)); flush = 1'b0;
      repeat (8) feed(1'b1, 16'h0000);
      idle(2);

      // randomized traffic including programming, commits and flushes
      for (int n = 0; n < 300; n++) begin
         coef_we     = ($urandom_range(7) == 0);
         coef_addr   = 3'($urandom_range(7));
         coef_data   = 8'($urandom_range(255));
         coef_commit = ($urandom_range(15) == 0);
         flush       = ($urandom_range(31) == 0);
         feed($urandom_range(3) != 0, enc(int'($urandom_range(510)) - 255));
      end
      coef_we = 1'b0; coef_commit = 1'b0; flush = 1'b0;

      // reprogram, reset with a result in flight, then defaults must be back
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'd200; coef_commit = 1'b1;
      step();
      coef_we = 1'b0; coef_commit = 1'b0;
      feed(1'b1, enc(50));
      nrst = 1'b0; step(); nrst = 1'b1;
      idle(3);
      feed(1'b1, 16'h0002); feed(1'b1, 16'h0000); feed(1'b1, 16'h0000);
      check_const("after_reset", 2);
      feed(1'b1, 16'h0000);
      check_const("after_reset_tap1", 14);
      repeat (4) feed(1'b1, 16'h0000);
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/online_fir_zero_prog.md
Name: online_fir_zero_prog

Overview:
- Parametrised successor to the fixed 8-tap online zero section (FIR numerator) of the overclocking IIR test platform.
- Computes y = sum_k c_k * x[n-k] on borrow-save signed-digit data with TAPS taps.
- Coefficients are runtime-programmable and double-banked, with an atomic commit.
- Adds a valid handshake, a flush and a fixed 2-cycle pipeline; sits ahead of the pole section in the IIR datapath.

Parameters:
- STAGE, 8, number of input digits; din width is 2*STAGE.
- TAPS, 8, number of filter taps (>=2).
- CW, 8, coefficient width; coefficients are unsigned integers, 0..2^CW-1.
- COEF_INIT, {8'd2,8'd14,8'd44,8'd74,8'd74,8'd44,8'd14,8'd2}, packed TAPS*CW reset coefficients; tap 0 is in the LSBs.

Ports:
- clk  in  1  clock.
- nrst  in  1  synchronous active-low reset.
- in_valid  in  1  din is a new sample this cycle.
- flush  in  1  clear the delay line and pipeline.
- din  in  2*STAGE  input sample, signed-digit.
- coef_we  in  1  write the shadow coefficient bank.
- coef_addr  in  clog2(TAPS)  tap index to write.
- coef_data  in  CW  coefficient value to write.
- coef_commit  in  1  copy the shadow bank to the active bank.
- coef_pending  out  1  shadow bank written since the last commit.
- out_valid  out  1  data_out holds a new result.
- data_out  out  2*OD  filter output, signed-digit; OD = STAGE+CW+clog2(TAPS).

Behaviour:
- Interface: reset nrst, synchronous, active-low; clock clk.
- Digit encoding: digit i occupies bits [2i+1:2i]. Bit 2i+1 is plus, bit 2i is minus. The integer value is sum (p_i - m_i)*2^i. 2'b11 is a legal zero.
- data_out may use any redundant form, provided its value is exact. Benches check value only.
- Range: |x| <= 2^STAGE-1, so |y| < 2^OD. Overflow cannot occur and no saturation logic is present.
- Delay line: TAPS registers d0..d(TAPS-1).
  - On an edge with in_valid=1 and flush=0: d0<=din and d(k)<=d(k-1).
  - Otherwise the delay line holds. It does not clear when idle; this differs from the previous block.
- Pipeline, latency 2:
  - Stage 1 registers the TAPS products c_k*d_k, using the active bank as it stands at that edge.
  - Stage 2 registers the sum of the products into data_out.
  - Sample captured at edge n: out_valid=1 and data_out valid after edge n+2, held for one cycle of out_valid.
  - data_out holds its value between results.
- out_valid is a 2-deep shift of the capture strobe. Back-to-back in_valid gives continuous out_valid.
- Coefficient write: coef_we writes shadow[coef_addr]<=coef_data. An out-of-range addr (TAPS not a power of 2) is ignored.
- Commit: coef_commit sets active<=shadow at the edge.
  - A sample captured at the commit edge or later uses the new bank.
  - A sample captured earlier uses the old bank.
- Commit and coef_we in the same cycle: the commit copies the pre-write shadow. The write lands in the shadow and coef_pending stays 1.
- coef_pending: set by coef_we, cleared by coef_commit unless coef_we is also asserted that cycle.
- flush, priority over in_valid:
  - Clears d0..d(TAPS-1) and both out_valid pipeline bits.
  - data_out is unchanged.
  - Coefficients are unaffected.
  - A sample presented with flush=1 is dropped.
- Reset, including mid-operation, at the edge with nrst=0:
  - Delay line, product registers and data_out are cleared to 0.
  - out_valid=0, coef_pending=0.
  - Shadow and active banks are loaded with COEF_INIT.
  - In-flight results are discarded.

Decomposition:
- Shared include/package online_arith_defs:
  - Digit-encoding constants (PLUS/MINUS bit offsets).
  - A clog2 function.
  - OD width macro.
  - Default COEF_INIT.
- One natural sub-module, online_ccm_prog:
  - Combinational multiply of a STAGE-digit signed-digit value by a CW-bit unsigned coefficient, as a shifted sum of partial products.
  - Output is STAGE+CW digits.
  - Instantiated TAPS times via generate.
- The adder tree is built from the existing online_adder instances, padded to OD digits.

Test Plan:
- Impulse, defaults: din=16'h0002 with in_valid for 1 cycle, then 7 cycles of din=0 → eight out_valid pulses, values 2,14,44,74,74,44,14,2, each 2 cycles after its capture.
- Redundancy and sign: din=16'h0009 (value +1) produces the same response as 16'h0002. din=16'h0001 (-1) gives -2,-14,-44,-74,...
- Full scale: din=16'hAAAA (255) held for 8+ valid samples → steady-state value 255*268=68340. With 16'h5555: -68340.
- Commit timing: write taps to 1,0,0,...; assert commit on the same edge as capturing a 1-impulse → first output is 1, not 2; coef_pending goes 1→0. Write+commit in the same cycle → pending stays 1.
- Gaps and flush: impulse, 3 idle cycles, then zeros → outputs continue 14,44,... with no extra out_valid. flush mid-response → out_valid drops within 1 cycle and subsequent zeros give 0.
- Reset mid-stream: after reprogramming, pull nrst low for 1 cycle with a result in flight → no out_valid for that sample; coefficients revert to COEF_INIT (impulse gives 2,14,...).
